// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Pops 9-bit words from an upstream FIFO and sends each one as a serial
//   frame: start bit (0), 9 data bits LSB first, optional even-parity bit,
//   stop bit (1). The line idles high.
//
// Ports
//   clock  sole clock, rising edge
//   reset  asynchronous, active-low
//   pin    upstream FIFO not-empty (din valid)
//   din    word at the upstream FIFO read pointer
//   sin    stall to upstream FIFO; 0 = pop one word at this edge
//   txd    serial line (registered)
//   busy   frame in progress (registered)
//   TM     scan test mode; freezes the transmitter and shifts the data register
//   SI     scan serial in
//   SO     scan serial out (data register bit 8)
//
// State   | meaning
// IDLE    | line high, waiting for a word; only state that pops
// START   | sending start bit
// DATA    | sending 9 data bits, LSB first
// PARITY  | sending even parity of the loaded word
// STOP    | sending stop bit
module fifo_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pin,
  input  logic [8:0] din,
  output logic       sin,
  output logic       txd,
  output logic       busy,
  input  logic       TM,
  input  logic       SI,
  output logic       SO
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [3:0]    IDX_LAST = 4'd8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    idx_q, idx_d;
  logic [8:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          pop;
  logic          bit_end;

  // Reset is folded in so that no pop can be requested while held in reset.
  assign sin     = ~(reset & (state_q == IDLE) & pin & ~TM);
  assign pop     = ~sin;
  assign bit_end = (cyc_q == CYC_LAST);
  assign txd     = txd_q;
  assign busy    = busy_q;
  assign SO      = sh_q[8];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // txd only changes at bit boundaries, so a scan pulse in the middle of a
  // bit keeps the bit on the line intact; later bits come from whatever the
  // shift register holds after the scan.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    if (TM) begin
      sh_d = {sh_q[7:0], SI};
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            sh_d    = din;
            par_d   = ^din;
            cyc_d   = '0;
            idx_d   = '0;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          if (bit_end) begin
            cyc_d   = '0;
            txd_d   = sh_q[0];
            state_d = DATA;
          end else begin
            cyc_d = cyc_q + CYC_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_d = '0;
            sh_d  = {1'b0, sh_q[8:1]};
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              if (PARITY_EN != 0) begin
                txd_d   = par_q;
                state_d = PARITY;
              end else begin
                txd_d   = 1'b1;
                state_d = STOP;
              end
            end else begin
              idx_d = idx_q + 4'd1;
              txd_d = sh_q[1];
            end
          end else begin
            cyc_d = cyc_q + CYC_ONE;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cyc_d   = '0;
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            cyc_d = cyc_q + CYC_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc_d   = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cyc_d = cyc_q + CYC_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period; legal range 2..255.
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 = append even-parity bit after data, 0 = no parity bit.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pin  input  1  upstream FIFO not-empty flag; 1 = din holds a valid word.
REQ-006 SHALL have port din  input  9  word at the upstream FIFO read pointer.
REQ-007 SHALL have port sin  output  1  stall to upstream FIFO; 0 = pop one word at this rising edge.
REQ-008 SHALL have port txd  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  1 while a frame is being transmitted, registered.
REQ-010 SHALL have port TM  input  1  scan test mode; 1 = scan shift active.
REQ-011 SHALL have port SI  input  1  scan serial in.
REQ-012 SHALL have port SO  output  1  scan serial out, equal to shift register bit 8.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 sin SHALL be combinational: 0 only when state==IDLE and pin==1 and TM==0; otherwise 1.
REQ-015 On a rising edge with sin==0, SHALL load din into a 9-bit shift register, clear the bit-period and bit-index counters, and enter START.
REQ-016 IDLE SHALL last at least one cycle; no pop occurs in any state other than IDLE.
REQ-017 txd SHALL be 0 in START, shift register bit 0 in DATA (LSB first, register shifts right once per bit period), even parity of the loaded word in PARITY, and 1 in STOP and IDLE.
REQ-018 Every state except IDLE SHALL last exactly CLKS_PER_BIT cycles per bit; DATA SHALL last 9 bit periods.
REQ-019 Transitions: START->DATA; DATA->PARITY after bit 8 when PARITY_EN=1, else DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-020 Word popped at edge k: txd goes 0 at edge k; stop bit ends and IDLE is entered at edge k+(11+PARITY_EN)*CLKS_PER_BIT.
REQ-021 Back-to-back with pin held 1: frame-start spacing SHALL be (11+PARITY_EN)*CLKS_PER_BIT+1 cycles, with no words lost or duplicated.
REQ-022 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-023 Parity SHALL be computed from the word as loaded, independent of later din changes.
REQ-024 pin dropping to 0 mid-frame SHALL have no effect on the current frame.
REQ-025 With TM==1: FSM, counters, txd and busy SHALL hold; shift register SHALL shift {reg[7:0],SI} every edge; sin SHALL be 1.
REQ-026 TM deasserting mid-frame SHALL resume the frame from its held state, transmitting the scanned shift-register contents.
REQ-027 Counter widths SHALL be the minimum needed for CLKS_PER_BIT-1 and 8; counters SHALL not wrap within a state.

Reset
REQ-028 While reset==0, asynchronously and independent of clock: state=IDLE, counters=0, shift register=0, txd=1, busy=0.
REQ-029 While reset==0, sin SHALL be 1 (no pop); after release, the first pop occurs no earlier than the first rising edge with reset==1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with txd=1 immediately; the in-flight word is discarded and not re-requested.

Verification
REQ-031 CLKS_PER_BIT=4, PARITY_EN=1, one word din=9'h1A5 -> sin low for 1 cycle; txd bits 0,1,0,1,0,0,1,0,1,1,1,1 (start, data LSB first, parity=1, stop), each 4 cycles; busy high for 48 cycles.
REQ-032 pin held 1 with 3 queued words 9'h000, 9'h1FF, 9'h0F0 -> frames start 49 cycles apart; parity bits 0,1,0; exactly 3 pops.
REQ-033 PARITY_EN=0, din=9'h001 -> 11-bit frame 0,1,0,0,0,0,0,0,0,0,1; busy high for 44 cycles.
REQ-034 reset driven low in DATA bit 4 -> txd=1 and busy=0 without a clock edge; after release with pin=1, next word frames normally.
REQ-035 TM=1 in IDLE, shift in 9 bits of SI pattern 101010101 -> SO follows the pattern delayed 9 edges; sin stays 1; txd stays 1.
REQ-036 TM pulsed high for 5 cycles mid-DATA -> frame stretched by exactly 5 cycles; txd constant during the pulse.
